dmem_responder: RTL

DMEM_RESPONDER -- requirements
Module: dmem_responder

---
 rtl/dmem_responder.sv | 107 ++++++++++
 1 files changed

// File: rtl/dmem_responder.sv
// Single-port 32-bit data memory responder with a one-entry posted write buffer.
// Reads return registered data one cycle later; writes retire from the buffer on the following edge.
module dmem_responder #(
  parameter int AW    = 10,
  parameter int CNT_W = 32
) (
  input  logic             CLK,
  input  logic             RSTn,
  input  logic             CSN,
  input  logic             WEN,
  input  logic [11:0]      ADDR,
  input  logic [3:0]       BE,
  input  logic [31:0]      DI,
  output logic [31:0]      DOUT,
  output logic             ERR,
  output logic [CNT_W-1:0] RD_CNT,
  output logic [CNT_W-1:0] WR_CNT
);

  logic [31:0]      mem_q [2**AW];

  logic [31:0]      dout_q, dout_d;
  logic             err_q, err_d;
  logic [CNT_W-1:0] rd_cnt_q, rd_cnt_d;
  logic [CNT_W-1:0] wr_cnt_q, wr_cnt_d;
  logic             wb_vld_q, wb_vld_d;
  logic [AW-1:0]    wb_idx_q, wb_idx_d;
  logic [3:0]       wb_be_q, wb_be_d;
  logic [31:0]      wb_dat_q, wb_dat_d;

  logic [AW-1:0]    idx;
  logic [31:0]      fwd_word;

  // Upper address bits beyond the array simply wrap.
  assign idx = AW'(ADDR >> 2);

  // A read hitting the pending buffered write sees the buffered bytes.
  always_comb begin
    fwd_word = mem_q[idx];
    if (wb_vld_q && (wb_idx_q == idx)) begin
      for (int l = 0; l < 4; l++) begin
        if (wb_be_q[l]) fwd_word[8*l +: 8] = wb_dat_q[8*l +: 8];
      end
    end
  end

  always_comb begin
    dout_d   = dout_q;
    err_d    = 1'b0;
    rd_cnt_d = rd_cnt_q;
    wr_cnt_d = wr_cnt_q;
    wb_vld_d = 1'b0;
    wb_idx_d = wb_idx_q;
    wb_be_d  = wb_be_q;
    wb_dat_d = wb_dat_q;
    if (!CSN) begin
      err_d = (!WEN && (BE == 4'b0000)) || ((ADDR[1:0] != 2'b00) && (BE == 4'b1111));
      if (WEN) begin
        dout_d   = fwd_word;
        rd_cnt_d = rd_cnt_q + CNT_W'(1);
      end else begin
        wb_vld_d = 1'b1;
        wb_idx_d = idx;
        wb_be_d  = BE;
        wb_dat_d = DI;
        wr_cnt_d = wr_cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (!RSTn) begin
      dout_q   <= '0;
      err_q    <= 1'b0;
      rd_cnt_q <= '0;
      wr_cnt_q <= '0;
      wb_vld_q <= 1'b0;
    end else begin
      dout_q   <= dout_d;
      err_q    <= err_d;
      rd_cnt_q <= rd_cnt_d;
      wr_cnt_q <= wr_cnt_d;
      wb_vld_q <= wb_vld_d;
    end
  end

  always_ff @(posedge CLK) begin
    wb_idx_q <= wb_idx_d;
    wb_be_q  <= wb_be_d;
    wb_dat_q <= wb_dat_d;
  end

  // Retirement is suppressed on a reset edge so the pending write is dropped.
  always_ff @(posedge CLK) begin
    if (RSTn && wb_vld_q) begin
      for (int l = 0; l < 4; l++) begin
        if (wb_be_q[l]) mem_q[wb_idx_q][8*l +: 8] <= wb_dat_q[8*l +: 8];
      end
    end
  end

  assign DOUT   = dout_q;
  assign ERR    = err_q;
  assign RD_CNT = rd_cnt_q;
  assign WR_CNT = wr_cnt_q;

endmodule
